// File: rtl/playback_sequencer_pkg.sv
// Shared music player definitions: sequencer state encoding, song count and
// envelope parameter-select codes.
package playback_sequencer_pkg;

  localparam int NUM_SONGS = 4;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_CHANGE  = 2'd2
  } state_e;

  localparam logic [1:0] PSEL_ATTACK  = 2'd0;
  localparam logic [1:0] PSEL_DECAY   = 2'd1;
  localparam logic [1:0] PSEL_RELEASE = 2'd2;

  // Selection cycles attack -> decay -> release -> attack; code 3 is never produced.
  function automatic logic [1:0] next_param_sel(input logic [1:0] sel);
    return (sel == PSEL_RELEASE) ? PSEL_ATTACK : sel + 2'd1;
  endfunction

endpackage

// File: rtl/playback_sequencer_if.sv
// User buttons and song-reader event in, player control and envelope settings out.
interface playback_sequencer_if;
  logic       play_button;
  logic       next_button;
  logic       song_done;
  logic       dyn_button;
  logic       sel_button;
  logic       inc_button;
  logic       play;
  logic       reset_player;
  logic [1:0] song;
  logic       toggle_dynamics;
  logic [1:0] attack_time_pow;
  logic [1:0] decay_time_pow;
  logic [1:0] release_time_pow;
  logic [1:0] param_sel;

  modport master (
    output play_button, next_button, song_done, dyn_button, sel_button, inc_button,
    input  play, reset_player, song, toggle_dynamics,
           attack_time_pow, decay_time_pow, release_time_pow, param_sel
  );

  modport slave (
    input  play_button, next_button, song_done, dyn_button, sel_button, inc_button,
    output play, reset_player, song, toggle_dynamics,
           attack_time_pow, decay_time_pow, release_time_pow, param_sel
  );
endinterface

// File: rtl/playback_sequencer_down_counter.sv
// 4-bit loadable down counter that holds at zero; times the song-change hold.
module down_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (en && (count_q != 4'd0))
      count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= 4'd0;
    else
      count_q <= count_d;
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/playback_sequencer.sv
// Play/pause/skip sequencer for the music player plus envelope parameter editing.
// Every output is a flop, so each button press shows up exactly one clock later.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter bit LOOP_ALL     = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  playback_sequencer_if.slave io
);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic       cnt_load, cnt_en, cnt_zero;

  logic       play_q, play_d;
  logic       rp_q, rp_d;
  logic [1:0] song_q, song_d;
  logic       tdyn_q, tdyn_d;
  logic [1:0] att_q, att_d;
  logic [1:0] dec_q, dec_d;
  logic [1:0] rel_q, rel_d;
  logic [1:0] sel_q, sel_d;

  down_counter u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (4'(RESET_CYCLES - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PAUSED;
      ret_q   <= ST_PAUSED;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Player events are ignored while a change is in progress; the counter is
  // loaded with one less than the hold length because the entry edge counts.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_PAUSED: begin
        if (io.next_button) begin
          state_d  = ST_CHANGE;
          ret_d    = ST_PAUSED;
          cnt_load = 1'b1;
        end else if (io.play_button) begin
          state_d = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (io.song_done) begin
          state_d  = ST_CHANGE;
          ret_d    = ((song_q == 2'(NUM_SONGS - 1)) && !LOOP_ALL) ? ST_PAUSED : ST_PLAYING;
          cnt_load = 1'b1;
        end else if (io.next_button) begin
          state_d  = ST_CHANGE;
          ret_d    = ST_PLAYING;
          cnt_load = 1'b1;
        end else if (io.play_button) begin
          state_d = ST_PAUSED;
        end
      end
      ST_CHANGE: begin
        if (cnt_zero)
          state_d = ret_q;
        else
          cnt_en = 1'b1;
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  always_comb begin
    play_d = (state_d == ST_PLAYING);
    rp_d   = (state_d == ST_CHANGE);
    song_d = song_q;
    if ((state_q != ST_CHANGE) && (state_d == ST_CHANGE))
      song_d = song_q + 2'd1;

    tdyn_d = tdyn_q ^ io.dyn_button;
    sel_d  = io.sel_button ? next_param_sel(sel_q) : sel_q;

    // The increment targets the selection as it stood before any same-cycle step.
    att_d = att_q;
    dec_d = dec_q;
    rel_d = rel_q;
    if (io.inc_button) begin
      case (sel_q)
        PSEL_ATTACK:  att_d = att_q + 2'd1;
        PSEL_DECAY:   dec_d = dec_q + 2'd1;
        PSEL_RELEASE: rel_d = rel_q + 2'd1;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      play_q <= 1'b0;
      rp_q   <= 1'b1;
      song_q <= 2'd0;
      tdyn_q <= 1'b1;
      att_q  <= 2'd3;
      dec_q  <= 2'd3;
      rel_q  <= 2'd3;
      sel_q  <= PSEL_ATTACK;
    end else begin
      play_q <= play_d;
      rp_q   <= rp_d;
      song_q <= song_d;
      tdyn_q <= tdyn_d;
      att_q  <= att_d;
      dec_q  <= dec_d;
      rel_q  <= rel_d;
      sel_q  <= sel_d;
    end
  end

  assign io.play             = play_q;
  assign io.reset_player     = rp_q;
  assign io.song             = song_q;
  assign io.toggle_dynamics  = tdyn_q;
  assign io.attack_time_pow  = att_q;
  assign io.decay_time_pow   = dec_q;
  assign io.release_time_pow = rel_q;
  assign io.param_sel        = sel_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Scoreboard bench: two sequencers (LOOP_ALL=0 and 1) share one directed
// stimulus stream; expected outputs are queued by the driver and checked by a monitor.
module tb_playback_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  playback_sequencer_if io0 ();
  playback_sequencer_if io1 ();

  playback_sequencer #(.RESET_CYCLES(2), .LOOP_ALL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .io(io0.slave)
  );
  playback_sequencer #(.RESET_CYCLES(2), .LOOP_ALL(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .io(io1.slave)
  );

  typedef struct packed {
    logic       p0;
    logic       p1;
    logic       rp;
    logic [1:0] song;
    logic       td;
    logic [1:0] a;
    logic [1:0] d;
    logic [1:0] r;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   idx_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vec_n = 0;

  task automatic drive(input logic [6:0] in);
    reset           = in[6];
    io0.play_button = in[5];  io1.play_button = in[5];
    io0.next_button = in[4];  io1.next_button = in[4];
    io0.song_done   = in[3];  io1.song_done   = in[3];
    io0.dyn_button  = in[2];  io1.dyn_button  = in[2];
    io0.sel_button  = in[1];  io1.sel_button  = in[1];
    io0.inc_button  = in[0];  io1.inc_button  = in[0];
  endtask

  // in = {reset, play, next, done, dyn, sel, inc}; the rest is the state after the edge.
  task automatic add(input logic [6:0] in, input logic p0, input logic p1, input logic rp,
                     input logic [1:0] song, input logic td, input logic [1:0] a,
                     input logic [1:0] d, input logic [1:0] r, input logic [1:0] sel);
    exp_t e;
    @(negedge clk);
    drive(in);
    e = '{p0: p0, p1: p1, rp: rp, song: song, td: td, a: a, d: d, r: r, sel: sel};
    exp_q.push_back(e);
    idx_q.push_back(vec_n);
    vec_n++;
  endtask

  always begin
    exp_t e;
    int   idx;
    logic [13:0] act0, act1, want0, want1;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = idx_q.pop_front();
      act0  = {io0.play, io0.reset_player, io0.song, io0.toggle_dynamics,
               io0.attack_time_pow, io0.decay_time_pow, io0.release_time_pow, io0.param_sel};
      act1  = {io1.play, io1.reset_player, io1.song, io1.toggle_dynamics,
               io1.attack_time_pow, io1.decay_time_pow, io1.release_time_pow, io1.param_sel};
      want0 = {e.p0, e.rp, e.song, e.td, e.a, e.d, e.r, e.sel};
      want1 = {e.p1, e.rp, e.song, e.td, e.a, e.d, e.r, e.sel};
      n_cmp++;
      if (act0 !== want0) begin
        n_err++;
        $display("FAIL vec%0d loop0 {play,rp,song,td,att,dec,rel,sel}: got %b expected %b",
                 idx, act0, want0);
      end
      n_cmp++;
      if (act1 !== want1) begin
        n_err++;
        $display("FAIL vec%0d loop1 {play,rp,song,td,att,dec,rel,sel}: got %b expected %b",
                 idx, act1, want1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got %0d vectors left expected 0", exp_q.size());
    $fatal(1);
  end

  initial begin
    drive(7'b0000000);
    // reset held, then released: reset_player drops on the first free clock
    add(7'b1000000, 0, 0, 1, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b1000000, 0, 0, 1, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0100000, 1, 1, 0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    // next while playing: two-cycle change, back to playing
    add(7'b0010000, 0, 0, 1, 2'd1, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 1, 2'd1, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 1, 1, 0, 2'd1, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0010000, 0, 0, 1, 2'd2, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0100000, 0, 0, 1, 2'd2, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 1, 1, 0, 2'd2, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    // song_done + play together: change wins, play dropped; next in change ignored
    add(7'b0101000, 0, 0, 1, 2'd3, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0010000, 0, 0, 1, 2'd3, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 1, 1, 0, 2'd3, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0100000, 0, 0, 0, 2'd3, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    // next while paused wraps 3 -> 0 and returns paused; dyn toggles inside change
    add(7'b0010000, 0, 0, 1, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000100, 0, 0, 1, 2'd0, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd0, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0001000, 0, 0, 0, 2'd0, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0010000, 0, 0, 1, 2'd1, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 1, 2'd1, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd1, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0010000, 0, 0, 1, 2'd2, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 1, 2'd2, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd2, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0010000, 0, 0, 1, 2'd3, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 1, 2'd3, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd3, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    // playing song 3, song_done: LOOP_ALL=0 ends paused, LOOP_ALL=1 keeps playing
    add(7'b0100000, 1, 1, 0, 2'd3, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0001000, 0, 0, 1, 2'd0, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 1, 2'd0, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 1, 0, 2'd0, 0, 2'd3, 2'd3, 2'd3, 2'd0);
    // envelope editing: decay 3 -> 0 -> 1, sel+inc hits release, wrap to attack
    add(7'b0000010, 0, 1, 0, 2'd0, 0, 2'd3, 2'd3, 2'd3, 2'd1);
    add(7'b0000001, 0, 1, 0, 2'd0, 0, 2'd3, 2'd0, 2'd3, 2'd1);
    add(7'b0000001, 0, 1, 0, 2'd0, 0, 2'd3, 2'd1, 2'd3, 2'd1);
    add(7'b0000010, 0, 1, 0, 2'd0, 0, 2'd3, 2'd1, 2'd3, 2'd2);
    add(7'b0000011, 0, 1, 0, 2'd0, 0, 2'd3, 2'd1, 2'd0, 2'd0);
    add(7'b0000001, 0, 1, 0, 2'd0, 0, 2'd0, 2'd1, 2'd0, 2'd0);
    add(7'b0000100, 0, 1, 0, 2'd0, 1, 2'd0, 2'd1, 2'd0, 2'd0);
    // reset in the middle of a change: full reset values, no stale return target
    add(7'b0010000, 0, 0, 1, 2'd1, 1, 2'd0, 2'd1, 2'd0, 2'd0);
    add(7'b1000000, 0, 0, 1, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0000000, 0, 0, 0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    add(7'b0100000, 1, 1, 0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 2'd0);
    @(negedge clk);
    drive(7'b0000000);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d unchecked vectors expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
